// File: rtl/ddr_test_sequencer.sv
// Command sequencer for the DDR3 traffic generator: a sequential fill of the
// test space followed by LFSR-driven random bursts, with completion tracking and a hang timeout.
module ddr_test_sequencer #(
    parameter int          CTRL_ADDR_WIDTH = 28,
    parameter int          MEM_SPACE_AW    = 18,
    parameter logic [31:0] LFSR_SEED       = 32'h1357_9BDF,
    parameter int          TIMEOUT_CYC     = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ddr_init_done,
    input  logic                       test_start,
    input  logic [1:0]                 test_mode,
    input  logic                       write_done_p,
    input  logic                       read_done_p,
    output logic                       write_en,
    output logic                       read_en,
    output logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
    output logic [3:0]                 random_axi_id,
    output logic [3:0]                 random_axi_len,
    output logic                       init_fill_done,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [31:0]                wr_cmd_cnt,
    output logic [31:0]                rd_cmd_cnt
);
    localparam int          BW       = MEM_SPACE_AW - 7;
    localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] SEED     = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [BW-1:0] BLK_LAST = {BW{1'b1}};

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WR, S_RD, S_GAP, S_HALT} state_t;
    typedef enum logic [1:0] {T_FILL, T_RD, T_MODE} gap_tgt_t;

    state_t      r_state, w_state_next;
    gap_tgt_t    r_gap_tgt, w_gap_tgt_next;
    logic        r_pair, w_pair_next;
    logic [31:0] r_lfsr, w_lfsr_next, w_lfsr_step, w_load_src;
    logic [BW-1:0] r_blk, w_blk_next;
    logic [3:0]  r_id, w_id_next, r_len, w_len_next;
    logic        r_fill_done, w_fill_done_next, r_tmo_err, w_tmo_err_next;
    logic [31:0] r_wr_cnt, w_wr_cnt_next, r_rd_cnt, w_rd_cnt_next;
    logic [TW-1:0] r_tmo, w_tmo_next;
    logic        r_wen, w_wen_next, r_ren, w_ren_next, r_busy, w_busy_next;
    logic        w_load, w_tmo_hit;

    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gap_tgt <= T_FILL;
            r_pair    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_gap_tgt <= w_gap_tgt_next;
            r_pair    <= w_pair_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_gap_tgt_next = r_gap_tgt;
        w_pair_next    = r_pair;
        case (r_state)
            S_IDLE: if (test_start && ddr_init_done) begin
                w_gap_tgt_next = T_MODE;
                w_state_next   = r_fill_done ? S_GAP : S_FILL;
            end
            S_FILL: if (write_done_p) begin
                w_gap_tgt_next = (r_blk == BLK_LAST) ? T_MODE : T_FILL;
                w_state_next   = test_start ? S_GAP : S_IDLE;
            end else if (w_tmo_hit) begin
                w_state_next = S_HALT;
            end
            S_WR: if (write_done_p) begin
                // a paired write hands the same burst to the following read
                w_gap_tgt_next = r_pair ? T_RD : T_MODE;
                w_state_next   = test_start ? S_GAP : S_IDLE;
            end else if (w_tmo_hit) begin
                w_state_next = S_HALT;
            end
            S_RD: if (read_done_p) begin
                w_gap_tgt_next = T_MODE;
                w_state_next   = test_start ? S_GAP : S_IDLE;
            end else if (w_tmo_hit) begin
                w_state_next = S_HALT;
            end
            S_GAP: begin
                case (r_gap_tgt)
                    T_FILL:  w_state_next = S_FILL;
                    T_RD:    w_state_next = S_RD;
                    default: begin
                        w_state_next = (test_mode == 2'd1) ? S_RD : S_WR;
                        w_pair_next  = (test_mode != 2'd2);
                    end
                endcase
            end
            S_HALT: if (!test_start) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_lfsr_step      = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
        w_lfsr_next      = r_lfsr;
        w_load_src       = r_lfsr;
        w_load           = 1'b0;
        w_blk_next       = r_blk;
        w_id_next        = r_id;
        w_len_next       = r_len;
        w_fill_done_next = r_fill_done;
        w_tmo_err_next   = r_tmo_err;
        w_wr_cnt_next    = r_wr_cnt;
        w_rd_cnt_next    = r_rd_cnt;
        case (r_state)
            S_IDLE: if (test_start && ddr_init_done) begin
                if (r_fill_done) begin
                    w_load = 1'b1;
                end else begin
                    w_blk_next = '0;
                    w_id_next  = 4'h0;
                    w_len_next = 4'hF;
                end
            end
            S_FILL: if (write_done_p) begin
                w_wr_cnt_next = r_wr_cnt + 32'd1;
                // r_blk doubles as the fill index while filling
                if (r_blk == BLK_LAST) begin
                    w_fill_done_next = 1'b1;
                    w_load           = 1'b1;
                end else begin
                    w_blk_next = r_blk + 1'b1;
                    w_id_next  = r_id + 4'd1;
                end
            end else if (w_tmo_hit) begin
                w_tmo_err_next = 1'b1;
            end
            S_WR: if (write_done_p) begin
                w_wr_cnt_next = r_wr_cnt + 32'd1;
                if (!r_pair) begin
                    w_lfsr_next = w_lfsr_step;
                    w_load_src  = w_lfsr_step;
                    w_load      = 1'b1;
                end
            end else if (w_tmo_hit) begin
                w_tmo_err_next = 1'b1;
            end
            S_RD: if (read_done_p) begin
                w_rd_cnt_next = r_rd_cnt + 32'd1;
                w_lfsr_next   = w_lfsr_step;
                w_load_src    = w_lfsr_step;
                w_load        = 1'b1;
            end else if (w_tmo_hit) begin
                w_tmo_err_next = 1'b1;
            end
            default: ;
        endcase
        if (w_load) begin
            w_len_next = w_load_src[11:8];
            w_id_next  = w_load_src[15:12];
            w_blk_next = w_load_src[31 -: BW];
        end
        if (w_state_next != r_state || !(r_state inside {S_FILL, S_WR, S_RD}))
            w_tmo_next = '0;
        else
            w_tmo_next = r_tmo + 1'b1;
        w_wen_next  = (w_state_next == S_FILL) || (w_state_next == S_WR);
        w_ren_next  = (w_state_next == S_RD);
        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr      <= SEED;
            r_blk       <= '0;
            r_id        <= 4'h0;
            r_len       <= 4'h0;
            r_fill_done <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_wr_cnt    <= 32'd0;
            r_rd_cnt    <= 32'd0;
            r_tmo       <= '0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_lfsr      <= w_lfsr_next;
            r_blk       <= w_blk_next;
            r_id        <= w_id_next;
            r_len       <= w_len_next;
            r_fill_done <= w_fill_done_next;
            r_tmo_err   <= w_tmo_err_next;
            r_wr_cnt    <= w_wr_cnt_next;
            r_rd_cnt    <= w_rd_cnt_next;
            r_tmo       <= w_tmo_next;
            r_wen       <= w_wen_next;
            r_ren       <= w_ren_next;
            r_busy      <= w_busy_next;
        end
    end

    assign write_en       = r_wen;
    assign read_en        = r_ren;
    assign random_rw_addr = CTRL_ADDR_WIDTH'({r_blk, 7'b0});
    assign random_axi_id  = r_id;
    assign random_axi_len = r_len;
    assign init_fill_done = r_fill_done;
    assign busy           = r_busy;
    assign timeout_err    = r_tmo_err;
    assign wr_cmd_cnt     = r_wr_cnt;
    assign rd_cmd_cnt     = r_rd_cnt;
endmodule

// File: tb/tb_ddr_test_sequencer.sv
// Randomized scoreboard bench for ddr_test_sequencer: a behavioural model predicts
// the command stream, a monitor compares every command as its enable rises.
module tb_ddr_test_sequencer;
    localparam int AW = 10, NB = AW - 7, NBLK = 1 << NB, TMO = 16;
    localparam logic [31:0] SEED = 32'h1357_9BDF;

    logic clk = 1'b0, rst = 1'b1;
    logic ddr_init_done = 1'b0, test_start = 1'b0, write_done_p = 1'b0, read_done_p = 1'b0;
    logic [1:0] test_mode = 2'd2;
    logic write_en, read_en, init_fill_done, busy, timeout_err;
    logic [27:0] random_rw_addr;
    logic [3:0] random_axi_id, random_axi_len;
    logic [31:0] wr_cmd_cnt, rd_cmd_cnt;

    ddr_test_sequencer #(.CTRL_ADDR_WIDTH(28), .MEM_SPACE_AW(AW), .LFSR_SEED(SEED), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ddr_init_done(ddr_init_done), .test_start(test_start),
        .test_mode(test_mode), .write_done_p(write_done_p), .read_done_p(read_done_p),
        .write_en(write_en), .read_en(read_en), .random_rw_addr(random_rw_addr),
        .random_axi_id(random_axi_id), .random_axi_len(random_axi_len),
        .init_fill_done(init_fill_done), .busy(busy), .timeout_err(timeout_err),
        .wr_cmd_cnt(wr_cmd_cnt), .rd_cmd_cnt(rd_cmd_cnt));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic [27:0] addr;
        logic [3:0]  len;
        logic [3:0]  id;
    } cmd_t;

    cmd_t exp_q[$];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_lfsr;
    bit   m_fill_done, m_cur_fill, m_cur_pair;
    int   m_fill_idx, m_wr, m_rd;
    cmd_t m_cur;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic cmd_t rand_cmd(input bit w, input logic [31:0] l);
        cmd_t c;
        c.is_wr = w;
        c.addr  = 28'((l >> (32 - NB)) * 128);
        c.len   = 4'((l >> 8) & 32'hF);
        c.id    = 4'((l >> 12) & 32'hF);
        return c;
    endfunction

    function automatic cmd_t fill_cmd(input int idx);
        cmd_t c;
        c.is_wr = 1'b1;
        c.addr  = 28'(idx * 128);
        c.len   = 4'd15;
        c.id    = 4'(idx % 16);
        return c;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_fill_done = 0; m_fill_idx = 0; m_wr = 0; m_rd = 0;
        exp_q.delete();
    endtask

    task automatic model_issue(input cmd_t c, input bit is_fill, input bit pair, input bit push);
        m_cur = c; m_cur_fill = is_fill; m_cur_pair = pair;
        if (push) exp_q.push_back(c);
    endtask

    task automatic model_random(input bit push);
        if (test_mode == 2'd1) model_issue(rand_cmd(0, m_lfsr), 0, 0, push);
        else                   model_issue(rand_cmd(1, m_lfsr), 0, test_mode != 2'd2, push);
    endtask

    task automatic model_start();
        if (!m_fill_done) begin
            m_fill_idx = 0;
            model_issue(fill_cmd(0), 1, 0, 1);
        end else begin
            model_random(1);
        end
    endtask

    task automatic model_done();
        bit go = test_start;
        if (m_cur_fill) begin
            m_wr++; m_fill_idx++;
            if (m_fill_idx == NBLK) begin
                m_fill_done = 1;
                model_random(go);
            end else begin
                model_issue(fill_cmd(m_fill_idx), 1, 0, go);
            end
        end else if (m_cur.is_wr) begin
            m_wr++;
            if (m_cur_pair) begin
                cmd_t c = m_cur;
                c.is_wr = 1'b0;
                model_issue(c, 0, 0, go);
            end else begin
                m_lfsr = lfsr_step(m_lfsr);
                model_random(go);
            end
        end else begin
            m_rd++;
            m_lfsr = lfsr_step(m_lfsr);
            model_random(go);
        end
    endtask

    // ---------------- controller responder ----------------
    bit pend = 0, prev_en = 0, done_now = 0, done_last = 0, withhold = 0, stray_en = 0;
    int cnt = 0, fixed_lat = 3;

    task automatic tick();
        bit en;
        @(negedge clk);
        write_done_p = 1'b0; read_done_p = 1'b0;
        done_now = 0;
        if (done_last && !rst) chk("gap_enables_low", {write_en, read_en}, 2'b00);
        done_last = 0;
        en = write_en | read_en;
        if (en && !prev_en) begin
            pend = 1;
            cnt = (fixed_lat > 0) ? fixed_lat - 1 : int'($urandom_range(0, 4));
        end
        prev_en = en;
        if (pend && en && !withhold) begin
            if (cnt == 0) begin
                if (write_en) write_done_p = 1'b1; else read_done_p = 1'b1;
                pend = 0; done_now = 1; done_last = 1;
                model_done();
            end else begin
                cnt--;
            end
        end
        if (stray_en && $urandom_range(0, 3) == 0) begin
            if (write_en) read_done_p = 1'b1;
            else if (read_en) write_done_p = 1'b1;
            else begin write_done_p = 1'b1; read_done_p = 1'b1; end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        cmd_t cur, prv, e;
        bit pw = 0, pr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin pw = 0; pr = 0; continue; end
            cur.is_wr = write_en; cur.addr = random_rw_addr;
            cur.len = random_axi_len; cur.id = random_axi_id;
            if (write_en && read_en) chk("both_enables", 1, 0);
            if ((write_en || read_en) && !(pw || pr)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 64'(cur), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd", 64'(cur), 64'(e));
                end
            end else if ((write_en && pw) || (read_en && pr)) begin
                if (cur != prv) chk("fields_stable", 64'(cur), 64'(prv));
            end
            prv = cur; pw = write_en; pr = read_en;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_run(input logic [1:0] mode);
        int n = 0;
        bit fill = !m_fill_done;
        test_mode = mode;
        test_start = 1'b1;
        model_start();
        while (!(write_en || read_en) && n < 10) begin tick(); n++; end
        chk("start_latency", n, fill ? 1 : 2);
    endtask

    task automatic wait_model(input bit wr, input int target);
        int n = 0;
        while (((wr ? m_wr : m_rd) < target) && n < 3000) begin tick(); n++; end
        if (n >= 3000) chk("wait_budget", n, 0);
    endtask

    task automatic stop_and_check();
        int n = 0;
        tick();
        while (done_now) tick();
        test_start = 1'b0;
        while (busy && n < 50) begin tick(); n++; end
        tick(); tick();
        chk("stopped_busy", busy, 0);
        chk("wr_cmd_cnt", wr_cmd_cnt, 32'(m_wr));
        chk("rd_cmd_cnt", rd_cmd_cnt, 32'(m_rd));
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) tick();
        chk("rst_write_en", write_en, 0);
        chk("rst_read_en", read_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fill_done", init_fill_done, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_addr", random_rw_addr, 0);
        chk("rst_cnts", {wr_cmd_cnt, rd_cmd_cnt}, 0);
        rst = 1'b0;
        ddr_init_done = 1'b1;
        repeat (2) tick();

        // fill with fixed latency, then random write-only traffic
        start_run(2'd2);
        wait_model(1, 7); tick(); tick();
        chk("fill_not_done_7", init_fill_done, 0);
        wait_model(1, 8); tick(); tick();
        chk("fill_done_8", init_fill_done, 1);
        chk("fill_wr_cnt", wr_cmd_cnt, 8);
        fixed_lat = 0; stray_en = 1;
        wait_model(1, 20);
        stop_and_check();

        // write-then-read pairing, stop during a read
        start_run(2'd0);
        wait_model(0, 8);
        fixed_lat = 3;
        n = 0;
        do begin tick(); n++; end while (!(read_en && pend && cnt > 0) && n < 500);
        test_start = 1'b0;
        n = 0;
        while (!done_now && n < 20) begin
            chk("rd_persists", read_en, 1);
            tick(); n++;
        end
        tick();
        chk("idle_after_rd", {busy, write_en, read_en}, 3'b000);
        stop_and_check();
        chk("fill_retained", init_fill_done, 1);

        fixed_lat = 0;
        start_run(2'd0);
        wait_model(0, m_rd + 4);
        stop_and_check();
        start_run(2'd1);
        wait_model(0, m_rd + 6);
        stop_and_check();
        start_run(2'd3);
        wait_model(0, m_rd + 4);

        // asynchronous reset in the middle of a write
        n = 0;
        do begin tick(); n++; end while (!write_en && n < 100);
        #2 rst = 1'b1;
        #1;
        chk("arst_write_en", write_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnts", {wr_cmd_cnt, rd_cmd_cnt}, 0);
        chk("arst_fill_done", init_fill_done, 0);
        test_start = 1'b0;
        model_reset();
        pend = 0; prev_en = 0; done_last = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // refill, then the first random burst must come from the seed again
        start_run(2'd0);
        wait_model(1, 10);

        // timeout on a withheld done pulse
        n = 0;
        do begin tick(); n++; end while (!done_now && n < 100);
        withhold = 1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (write_en || read_en) n++;
            if (timeout_err) break;
        end
        chk("timeout_cycles", n, TMO);
        chk("timeout_flag", timeout_err, 1);
        chk("halt_enables", {write_en, read_en}, 2'b00);
        chk("halt_busy", busy, 1);
        test_start = 1'b0;
        repeat (3) tick();
        chk("halt_to_idle", busy, 0);
        chk("timeout_sticky", timeout_err, 1);
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
